// File: rtl/wb_trace_monitor.sv
// Writeback trace monitor: shadows the architectural register file and queues
// timestamped register writes into a first-word-fall-through trace FIFO.
module wb_trace_monitor #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 8,
  parameter int CYC_W    = 16,
  parameter int PC_START = 12
) (
  input  logic                       reloj,
  input  logic                       resetM,
  input  logic [31:0]                P_C,
  input  logic                       REG_WR,
  input  logic [ADDR_W-1:0]          DIR_WRA,
  input  logic [DATA_W-1:0]          DI_banco,
  input  logic [DATA_W-1:0]          DO_D,
  input  logic                       WB_SEL,
  input  logic                       EN,
  input  logic                       MODE,
  input  logic [ADDR_W-1:0]          SH_ADDR,
  output logic [DATA_W-1:0]          SH_DATA,
  output logic                       TR_VALID,
  input  logic                       TR_READY,
  output logic [ADDR_W-1:0]          TR_ADDR,
  output logic [DATA_W-1:0]          TR_DATA,
  output logic [CYC_W-1:0]           TR_STAMP,
  output logic [$clog2(DEPTH):0]     COUNT,
  output logic                       FULL,
  output logic                       EMPTY,
  output logic [15:0]                OVF_CNT
);

  localparam int NREG  = 1 << ADDR_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [31:0]      PC_MIN  = 32'(PC_START);
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [15:0]      OVF_MAX = 16'hFFFF;

  logic [DATA_W-1:0] shadow_q     [NREG];
  logic [ADDR_W-1:0] fifo_addr_q  [DEPTH];
  logic [DATA_W-1:0] fifo_data_q  [DEPTH];
  logic [CYC_W-1:0]  fifo_stamp_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic [15:0]       ovf_q, ovf_d;
  logic [CYC_W-1:0]  cyc_q;
  logic [DATA_W-1:0] sh_data_q;

  logic [DATA_W-1:0] wb_data;
  logic              qualify;
  logic              push_req;
  logic              push;
  logic              pop;
  logic              drop;

  // Qualification and FIFO accounting; the change test sees the pre-update shadow.
  always_comb begin
    wb_data  = WB_SEL ? DO_D : DI_banco;
    qualify  = (REG_WR == 1'b0) && EN && (P_C >= PC_MIN) && (DIR_WRA != '0);
    push_req = qualify && ((MODE == 1'b0) || (wb_data != shadow_q[DIR_WRA]));
    pop      = !empty_q && TR_READY;
    push     = push_req && (!full_q || pop);
    drop     = push_req && full_q && !pop;

    if (push && !pop) begin
      count_d = count_q + (PTR_W+1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (PTR_W+1)'(1);
    end else begin
      count_d = count_q;
    end
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);

    if (drop && (ovf_q != OVF_MAX)) begin
      ovf_d = ovf_q + 16'd1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Shadow register file; r0 is never written because qualify excludes it.
  always_ff @(posedge reloj) begin
    if (resetM) begin
      for (int i = 0; i < NREG; i++) begin
        shadow_q[i] <= '0;
      end
      sh_data_q <= '0;
    end else begin
      if (qualify) begin
        shadow_q[DIR_WRA] <= wb_data;
      end
      sh_data_q <= shadow_q[SH_ADDR];
    end
  end

  // Trace FIFO storage; a push into a full FIFO only lands when a pop frees the slot.
  always_ff @(posedge reloj) begin
    if (resetM) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_addr_q[i]  <= '0;
        fifo_data_q[i]  <= '0;
        fifo_stamp_q[i] <= '0;
      end
    end else if (push) begin
      fifo_addr_q[wr_ptr_q]  <= DIR_WRA;
      fifo_data_q[wr_ptr_q]  <= wb_data;
      fifo_stamp_q[wr_ptr_q] <= cyc_q;
    end
  end

  // Pointers, flags, overflow counter and the free-running cycle stamp.
  always_ff @(posedge reloj) begin
    if (resetM) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= '0;
      cyc_q    <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
      cyc_q   <= cyc_q + CYC_W'(1);
    end
  end

  assign SH_DATA  = sh_data_q;
  assign TR_VALID = !empty_q;
  assign TR_ADDR  = empty_q ? '0 : fifo_addr_q[rd_ptr_q];
  assign TR_DATA  = empty_q ? '0 : fifo_data_q[rd_ptr_q];
  assign TR_STAMP = empty_q ? '0 : fifo_stamp_q[rd_ptr_q];
  assign COUNT    = count_q;
  assign FULL     = full_q;
  assign EMPTY    = empty_q;
  assign OVF_CNT  = ovf_q;

endmodule
